program_loader: RTL and testbench
=================================

# program_loader

On-chip counterpart of the host-side program server: runs the boot handshake over UART, receives the program image, writes it word by word into instruction memory, then signals the core to start. Sits between `UartRx`/`UartTx` and the instruction BRAM write port. Protocol, in order:
- loader sends 0x99;
- host sends a 4-byte little-endian byte count, then the image;
- loader sends 0xaa, after which the host streams data bytes straight to the core.

## Interface
- `ADDR_WIDTH`, 14: instruction memory word-address width; capacity 2^ADDR_WIDTH words.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; loading begins on the first cycle it is seen high in IDLE.
- `rx_ready` in 1: one-cycle pulse; `rdata`/`ferr` valid that cycle.
- `rdata` in 8: received byte.
- `ferr` in 1: framing error on the current byte.
- `tx_busy` in 1: transmitter busy; high from the cycle after `tx_start` until the stop bit ends.
- `tx_start` out 1: one-cycle transmit request.
- `sdata` out 8: byte to send; valid with `tx_start` and held afterwards.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_WIDTH: word address.
- `imem_wd` out 32: write data.
- `done` out 1: sticky; image loaded and 0xaa handed to the transmitter.
- `error` out 1: sticky; load aborted.

## Operation
States: IDLE, SEND_SYNC, RECV_SIZE, RECV_PROG, SEND_ACK, DONE, ERROR.
- IDLE: `start` high -> SEND_SYNC. `rx_ready` is ignored.
- SEND_SYNC: in the first cycle with `tx_busy`=0 and `tx_start`=0, pulse `tx_start` with `sdata`=0x99, then -> RECV_SIZE.
- RECV_SIZE: collect 4 bytes into `size`, little-endian (first byte is `size[7:0]`). On the 4th byte:
  - `size`=0 -> SEND_ACK.
  - `size[1:0]`!=0 or `size`>4·2^ADDR_WIDTH -> ERROR.
  - otherwise clear the byte index and word address -> RECV_PROG.
- RECV_PROG: assemble bytes little-endian into a 32-bit word. On the 4th byte of each word, write the word at the current address and increment the address. The write for word index `size`/4−1 moves to SEND_ACK.
- SEND_ACK: same rules as SEND_SYNC with `sdata`=0xaa, then -> DONE.
- DONE and ERROR are terminal until `reset`; `start` is ignored in both.
- `rx_ready` with `ferr`=1 in RECV_SIZE or RECV_PROG -> ERROR; the partial word is discarded and no write occurs.
- `rx_ready` in SEND_SYNC, SEND_ACK or DONE: byte dropped, no state effect. DONE-state bytes belong to the core.
- Byte counter is 2 bits and wraps 3->0 on each word boundary. Word address is ADDR_WIDTH bits and never wraps, because the bound check above prevents overflow.

## Timing
- Reset values: `tx_start`=0, `sdata`=0, `imem_we`=0, `imem_addr`=0, `imem_wd`=0, `done`=0, `error`=0; state IDLE; byte counter 0; `size` 0.
- Reset mid-operation: takes effect next edge. Any pending write is cancelled and partial data is discarded.
- IDLE -> `tx_start` high no earlier than 2 cycles after `start` (IDLE->SEND_SYNC, then pulse), given `tx_busy`=0.
- `tx_start` is exactly one cycle wide. It is never reasserted while `tx_busy`=1 or in the cycle right after a pulse.
- Memory write latency is 1 cycle: the `rx_ready` cycle of byte 4 is followed by `imem_we`=1 with `imem_addr`/`imem_wd` valid. `imem_we` drops the next cycle; addr/wd hold their values.
- Back-to-back writes are spaced at least 4 `rx_ready` pulses apart.
- `done` rises in the cycle after the 0xaa `tx_start` pulse.
- `error` rises in the cycle after the offending byte.

## Test plan
- **Normal load:** `start`; bench answers the 0x99 with size bytes 0c 00 00 00, then 78 56 34 12 / ef be ad de / 01 00 00 00 -> writes 0x12345678@0, 0xdeadbeef@1, 0x00000001@2. Then 0xaa is transmitted and `done`=1.
- **Empty program:** size 00 00 00 00 -> no `imem_we`; 0xaa sent; `done`=1.
- **Bad size:** size 06 00 00 00 -> `error`=1; no writes; no 0xaa; later bytes ignored.
- **Framing error:** `ferr`=1 on the 6th program byte -> only word 0 written; `error`=1; `done` stays 0.
- **Reset mid-load:** `reset` after byte 2 of word 1 -> all outputs at reset values. Re-running the normal load succeeds and word 1 has no stale bytes.
- **Transmitter back-pressure:** `tx_busy` held high for 50 cycles after `start` -> `tx_start` stays low until cycle 51. 0x99 is sent exactly once; a stray `rx_ready` during SEND_SYNC has no effect.

Source files
------------

// File: rtl/program_loader_if.sv
// Boot-loader bundle: UART byte stream in, transmit requests out, instruction-memory
// write port out, plus status and a state debug tap.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    // Handshake: rx_ready is a one-cycle valid with no back-pressure, so rdata/ferr
    // are consumed in that same cycle. tx_start is a one-cycle request that is only
    // raised while tx_busy is low, and sdata is held until the next request.
    logic                  start;
    logic                  rx_ready;
    logic [7:0]            rdata;
    logic                  ferr;
    logic                  tx_busy;
    logic                  tx_start;
    logic [7:0]            sdata;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wd;
    logic                  done;
    logic                  error;
    logic [2:0]            state;

    modport master (
        input  start, rx_ready, rdata, ferr, tx_busy,
        output tx_start, sdata, imem_we, imem_addr, imem_wd, done, error, state
    );

    modport slave (
        output start, rx_ready, rdata, ferr, tx_busy,
        input  tx_start, sdata, imem_we, imem_addr, imem_wd, done, error, state
    );
endinterface

// File: rtl/program_loader.sv
// Receives a size-prefixed program image over UART and writes it word by word
// into instruction memory, bracketed by 0x99 / 0xaa handshake bytes.
module program_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic              clock,
    input  logic              reset,
    program_loader_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_SYNC = 3'd1,
        RECV_SIZE = 3'd2,
        RECV_PROG = 3'd3,
        SEND_ACK  = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    localparam logic [32:0] MAX_BYTES = 33'd4 << ADDR_WIDTH;

    state_t                state_q, state_n;
    logic [1:0]            cnt_q, cnt_n;
    logic [31:0]           size_q, size_n;
    logic [31:0]           word_q, word_n;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_n;
    logic                  tx_start_q, tx_start_n;
    logic [7:0]            sdata_q, sdata_n;
    logic                  we_q, we_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [31:0]           wd_q, wd_n;
    logic                  done_q, done_n;
    logic                  error_q, error_n;

    logic [31:0]           size_full;
    logic [31:0]           word_full;
    logic                  last_word;

    // Bytes arrive least-significant first, so each one shifts in from the top.
    assign size_full = {bus.rdata, size_q[31:8]};
    assign word_full = {bus.rdata, word_q[31:8]};
    assign last_word = (({1'b0, waddr_q} + (ADDR_WIDTH+1)'(1)) == size_q[ADDR_WIDTH+2:2]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            tx_start_q <= 1'b0;
            sdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            size_q     <= size_n;
            word_q     <= word_n;
            waddr_q    <= waddr_n;
            tx_start_q <= tx_start_n;
            sdata_q    <= sdata_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            wd_q       <= wd_n;
            done_q     <= done_n;
            error_q    <= error_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        size_n     = size_q;
        word_n     = word_q;
        waddr_n    = waddr_q;
        tx_start_n = 1'b0;
        sdata_n    = sdata_q;
        we_n       = 1'b0;
        addr_n     = addr_q;
        wd_n       = wd_q;
        done_n     = done_q;
        error_n    = error_q;

        case (state_q)
            IDLE: begin
                if (bus.start) state_n = SEND_SYNC;
            end
            SEND_SYNC: begin
                if (!bus.tx_busy && !tx_start_q) begin
                    tx_start_n = 1'b1;
                    sdata_n    = 8'h99;
                    state_n    = RECV_SIZE;
                end
            end
            RECV_SIZE: begin
                if (bus.rx_ready) begin
                    if (bus.ferr) begin
                        state_n = ERROR;
                        error_n = 1'b1;
                    end else begin
                        size_n = size_full;
                        cnt_n  = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cnt_n = '0;
                            if (size_full == 32'd0) begin
                                state_n = SEND_ACK;
                            end else if (size_full[1:0] != 2'b00 ||
                                         {1'b0, size_full} > MAX_BYTES) begin
                                state_n = ERROR;
                                error_n = 1'b1;
                            end else begin
                                waddr_n = '0;
                                state_n = RECV_PROG;
                            end
                        end
                    end
                end
            end
            RECV_PROG: begin
                if (bus.rx_ready) begin
                    if (bus.ferr) begin
                        state_n = ERROR;
                        error_n = 1'b1;
                    end else begin
                        word_n = word_full;
                        cnt_n  = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            we_n    = 1'b1;
                            addr_n  = waddr_q;
                            wd_n    = word_full;
                            waddr_n = waddr_q + ADDR_WIDTH'(1);
                            if (last_word) state_n = SEND_ACK;
                        end
                    end
                end
            end
            SEND_ACK: begin
                if (!bus.tx_busy && !tx_start_q) begin
                    tx_start_n = 1'b1;
                    sdata_n    = 8'haa;
                    state_n    = DONE;
                end
            end
            // done trails the 0xaa request by one cycle because it is set from DONE.
            DONE: begin
                done_n = 1'b1;
            end
            ERROR: begin
                error_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.sdata     = sdata_q;
    assign bus.imem_we   = we_q;
    assign bus.imem_addr = addr_q;
    assign bus.imem_wd   = wd_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of load scenarios plus hand-written
// reset-mid-load and transmitter back-pressure sequences.
module tb_program_loader;
    localparam int AW = 14;
    localparam int W  = AW + 32;

    typedef struct {
        logic [31:0] size;
        int          nprog;
        int          ferr_at;
        int          exp_wr;
        logic        exp_done;
        logic        exp_err;
        int          exp_tx;
        logic [2:0]  exp_state;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();
    program_loader #(.ADDR_WIDTH(AW)) dut (.clock(clk), .reset(rst), .bus(bus));

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_log[$];
    logic [7:0]   tx_log[$];
    logic [31:0]  words[3];
    vec_t         vecs[9];
    int           last_rx_cyc = -10;
    int           lat_viol = 0;
    int           pulse_viol = 0;
    int           ack_cyc = -1;
    int           done_rise_cyc = -1;
    logic         prev_we = 1'b0, prev_tx = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    int           wr_base, tx_base, lat0, pulse0;

    // Output monitor: logs writes and transmit requests and records timing.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_log.push_back({bus.imem_addr, bus.imem_wd});
            if (cyc != last_rx_cyc + 1) lat_viol++;
            if (prev_we) pulse_viol++;
        end
        if (bus.tx_start) begin
            tx_log.push_back(bus.sdata);
            if (prev_tx || prev_busy) pulse_viol++;
            if (bus.sdata == 8'haa) ack_cyc = cyc;
        end
        if (bus.done && !prev_done) done_rise_cyc = cyc;
        if (bus.rx_ready) last_rx_cyc = cyc;
        prev_we   = bus.imem_we;
        prev_tx   = bus.tx_start;
        prev_busy = bus.tx_busy;
        prev_done = bus.done;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        bus.rx_ready = 1'b1;
        bus.rdata    = b;
        bus.ferr     = fe;
        tick();
        bus.rx_ready = 1'b0;
        bus.ferr     = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic mark_bases();
        wr_base = wr_log.size();
        tx_base = tx_log.size();
        lat0    = lat_viol;
        pulse0  = pulse_viol;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_start"}, bus.tx_start, 0);
        check({tag, "_sdata"}, bus.sdata, 0);
        check({tag, "_imem_we"}, bus.imem_we, 0);
        check({tag, "_imem_addr"}, bus.imem_addr, 0);
        check({tag, "_imem_wd"}, bus.imem_wd, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
        check({tag, "_state"}, bus.state, 0);
    endtask

    task automatic start_and_sync(input string tag);
        int n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (tx_log.size() <= tx_base && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_sync_seen"}, tx_log.size() > tx_base, 1);
    endtask

    task automatic feed(input vec_t v);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) send_byte(v.size[8*i +: 8], 1'b0);
        for (int k = 0; k < v.exp_wr; k++) exp_q.push_back({k[AW-1:0], words[k]});
        for (int i = 0; i < v.nprog; i++) begin
            b = words[i/4][8*(i%4) +: 8];
            if (i == v.ferr_at) begin
                check("err_before_ferr", bus.error, 0);
                bus.rx_ready = 1'b1;
                bus.rdata    = b;
                bus.ferr     = 1'b1;
                tick();
                bus.rx_ready = 1'b0;
                bus.ferr     = 1'b0;
                check("err_after_ferr", bus.error, 1);
                tick();
                tick();
            end else begin
                send_byte(b, 1'b0);
            end
        end
        repeat (20) tick();
    endtask

    task automatic check_results(input vec_t v, input string tag);
        int n;
        int nt;
        n = wr_log.size() - wr_base;
        check({tag, "_wr_count"}, n, v.exp_wr);
        for (int j = 0; j < n; j++) begin
            if (exp_q.size() > 0) check($sformatf("%s_wr%0d", tag, j), wr_log[wr_base+j], exp_q.pop_front());
        end
        exp_q.delete();
        nt = tx_log.size() - tx_base;
        check({tag, "_tx_count"}, nt, v.exp_tx);
        if (nt >= 1) check({tag, "_tx0_sync"}, tx_log[tx_base], 8'h99);
        if (nt >= 2) check({tag, "_tx1_ack"}, tx_log[tx_base+1], 8'haa);
        check({tag, "_done"}, bus.done, v.exp_done);
        check({tag, "_error"}, bus.error, v.exp_err);
        check({tag, "_state"}, bus.state, v.exp_state);
        if (v.exp_done) check({tag, "_done_timing"}, done_rise_cyc, ack_cyc + 1);
        check({tag, "_write_latency"}, lat_viol, lat0);
        check({tag, "_pulse_rules"}, pulse_viol, pulse0);
    endtask

    task automatic run_load(input vec_t v, input string tag, input bit with_reset);
        if (with_reset) do_reset();
        mark_bases();
        start_and_sync(tag);
        feed(v);
        check_results(v, tag);
    endtask

    initial begin
        int hi;
        words[0] = 32'h12345678;
        words[1] = 32'hdeadbeef;
        words[2] = 32'h00000001;
        //          size          nprog ferr wr done err tx state
        vecs[0] = '{32'd12,         12, -1, 3, 1'b1, 1'b0, 2, 3'd5}; // normal
        vecs[1] = '{32'd0,           0, -1, 0, 1'b1, 1'b0, 2, 3'd5}; // empty
        vecs[2] = '{32'd6,           6, -1, 0, 1'b0, 1'b1, 1, 3'd6}; // misaligned
        vecs[3] = '{32'd12,         12,  5, 1, 1'b0, 1'b1, 1, 3'd6}; // framing error
        vecs[4] = '{32'd4,           4, -1, 1, 1'b1, 1'b0, 2, 3'd5}; // single word
        vecs[5] = '{32'h00010004,    4, -1, 0, 1'b0, 1'b1, 1, 3'd6}; // one word too big
        vecs[6] = '{32'h00010000,    8, -1, 2, 1'b0, 1'b0, 1, 3'd3}; // exactly full memory
        vecs[7] = '{32'h80000000,    0, -1, 0, 1'b0, 1'b1, 1, 3'd6}; // huge
        vecs[8] = '{32'd13,          4, -1, 0, 1'b0, 1'b1, 1, 3'd6}; // odd size

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rdata    = 8'h00;
        bus.ferr     = 1'b0;
        bus.tx_busy  = 1'b0;
        tick();
        tick();
        check_reset_vals("por");
        rst = 1'b0;
        tick();

        // start must be seen before anything else; IDLE ignores received bytes
        send_byte(8'h0c, 1'b0);
        check("idle_ignores_rx", bus.state, 0);

        for (int i = 0; i < 9; i++) run_load(vecs[i], $sformatf("v%0d", i), 1'b1);

        // reset in the middle of word 1, then reload without another reset
        do_reset();
        mark_bases();
        start_and_sync("midrst");
        for (int i = 0; i < 4; i++) send_byte(vecs[0].size[8*i +: 8], 1'b0);
        for (int i = 0; i < 4; i++) send_byte(words[0][8*i +: 8], 1'b0);
        send_byte(8'hef, 1'b0);
        send_byte(8'hbe, 1'b0);
        check("midrst_pre_wr_count", wr_log.size() - wr_base, 1);
        if (wr_log.size() > wr_base) check("midrst_pre_wr0", wr_log[wr_base], {{AW{1'b0}}, words[0]});
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        tick();
        run_load(vecs[0], "reload", 1'b0);

        // transmitter back-pressure with a stray byte during SEND_SYNC
        do_reset();
        mark_bases();
        bus.start   = 1'b1;
        bus.tx_busy = 1'b1;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                bus.rx_ready = 1'b1;
                bus.rdata    = 8'h0c;
            end else begin
                bus.rx_ready = 1'b0;
            end
            tick();
            bus.start = 1'b0;
            if (bus.tx_start) hi++;
        end
        check("bp_tx_low_while_busy", hi, 0);
        check("bp_state_sync", bus.state, 1);
        bus.tx_busy = 1'b0;
        tick();
        check("bp_tx_at_51", bus.tx_start, 1);
        check("bp_sdata", bus.sdata, 8'h99);
        tick();
        check("bp_tx_one_cycle", bus.tx_start, 0);
        feed(vecs[0]);
        check_results(vecs[0], "bp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1);
    end
endmodule
